// File: rtl/sdu_pkg.sv
// ---------------------------------------------------------------------------
// sdu_pkg
// Shared definitions for the Doppler slow-time chain (segmenter, window LUT,
// FFT feeder).
//   SDU_DATA_W    : default sample width in bits (signed two's complement)
//   SDU_FRAME_LEN : default samples per frame (window LUT depth)
//   SDU_FRAME_AW  : frame address width shared with the window LUT
//   seg_state_t   : segmenter FSM states FILL / WAIT / READ
// ---------------------------------------------------------------------------
package sdu_pkg;

   localparam int SDU_DATA_W    = 32;
   localparam int SDU_FRAME_LEN = 128;
   localparam int SDU_FRAME_AW  = 7;

   // FILL : priming the buffer with the very first frame after reset
   // WAIT : counting new samples until the next hop completes
   // READ : streaming one frame out of the circular buffer
   typedef enum logic [1:0] {
      FILL = 2'd0,
      WAIT = 2'd1,
      READ = 2'd2
   } seg_state_t;

endpackage

// File: rtl/seg_frame_ram.sv
// ---------------------------------------------------------------------------
// seg_frame_ram
// Simple dual-port synchronous RAM backing the segmenter circular buffer.
// Kept in its own module so synthesis maps it onto block RAM.
// Ports:
//   clk     : clock, both ports on rising edge
//   wr_en   : write strobe
//   wr_addr : write address
//   wr_data : write data
//   rd_en   : read strobe; rd_data updates one cycle after the address
//   rd_addr : read address
//   rd_data : registered read data (holds when rd_en is low)
// ---------------------------------------------------------------------------
module seg_frame_ram #(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 256,
   parameter int AW     = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              wr_en,
   input  logic [AW-1:0]     wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              rd_en,
   input  logic [AW-1:0]     rd_addr,
   output logic [DATA_W-1:0] rd_data
);

   logic [DATA_W-1:0] mem [DEPTH];

   // The storage array is deliberately left without a reset so that it maps
   // onto block RAM. The segmenter never reads a slot before writing it after
   // a reset, so stale contents are harmless.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
      if (rd_en) begin
         rd_data <= mem[rd_addr];
      end
   end

endmodule

// File: rtl/doppler_frame_segmenter.sv
// ---------------------------------------------------------------------------
// doppler_frame_segmenter
// Cuts the continuous slow-time Doppler sample stream into overlapping
// FRAME_LEN-sample bursts for the Hamming window / FFT chain. A new frame
// starts every HOP accepted samples, so consecutive frames share
// FRAME_LEN-HOP samples. If a new frame becomes due while the previous one is
// still being read out it is dropped and overrun_F pulses.
//
// Optional build macro: SEG_OVERRUN_CNT_EN adds the saturating overrun_cnt_F
// dropped-frame counter port.
//
// Ports:
//   clk           : clock, rising edge
//   reset         : asynchronous active-high reset
//   in_data       : signed input sample
//   in_valid      : qualifies in_data, at most one per cycle, no backpressure
//   out_data_F    : registered frame sample, holds between frames
//   out_valid_F   : qualifies out_data_F
//   out_sof_F     : first sample of a frame
//   out_eof_F     : last sample of a frame
//   overrun_F     : one-cycle pulse per dropped frame
//   overrun_cnt_F : saturating dropped-frame count (SEG_OVERRUN_CNT_EN only)
// ---------------------------------------------------------------------------
module doppler_frame_segmenter
   import sdu_pkg::*;
#(
   parameter int DATA_W    = SDU_DATA_W,
   parameter int FRAME_LEN = SDU_FRAME_LEN,
   parameter int HOP       = 64
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic signed [DATA_W-1:0] in_data,
   input  logic                     in_valid,
   output logic signed [DATA_W-1:0] out_data_F,
   output logic                     out_valid_F,
   output logic                     out_sof_F,
   output logic                     out_eof_F,
   output logic                     overrun_F
`ifdef SEG_OVERRUN_CNT_EN
   ,
   output logic [15:0]              overrun_cnt_F
`endif
);

   localparam int DEPTH    = 2 * FRAME_LEN;
   localparam int AW       = $clog2(DEPTH);
   localparam int FRAME_AW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
   localparam int NEW_W    = (HOP > 1) ? $clog2(HOP) : 1;

   seg_state_t        state;
   seg_state_t        state_next;

   logic [AW-1:0]       wr_ptr;
   logic [AW-1:0]       rd_ptr;
   logic [FRAME_AW-1:0] rd_cnt;
   logic [FRAME_AW-1:0] fill_cnt;
   logic [NEW_W-1:0]    new_cnt;

   logic hop_hit;
   logic trigger;
   logic overrun_hit;
   logic rd_en;
   logic rd_first;
   logic rd_last;

   logic [DATA_W-1:0] ram_q;
   logic              ram_vld_q;
   logic              ram_sof_q;
   logic              ram_eof_q;

   seg_frame_ram #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .AW     (AW)
   ) u_ram (
      .clk     (clk),
      .wr_en   (in_valid),
      .wr_addr (wr_ptr),
      .wr_data (in_data),
      .rd_en   (rd_en),
      .rd_addr (rd_ptr),
      .rd_data (ram_q)
   );

   // Next-state and frame-trigger decode. A hop completing during READ is
   // only honoured on the very last read cycle (the FSM chains straight into
   // the next frame); any earlier it is an overrun and the frame is dropped.
   always_comb begin
      state_next  = state;
      trigger     = 1'b0;
      overrun_hit = 1'b0;
      hop_hit     = in_valid && (new_cnt == NEW_W'(HOP - 1));
      rd_en       = (state == READ);
      rd_first    = rd_en && (rd_cnt == '0);
      rd_last     = rd_en && (rd_cnt == FRAME_AW'(FRAME_LEN - 1));

      case (state)
         FILL: begin
            if (in_valid && (fill_cnt == FRAME_AW'(FRAME_LEN - 1))) begin
               trigger    = 1'b1;
               state_next = READ;
            end
         end
         WAIT: begin
            if (hop_hit) begin
               trigger    = 1'b1;
               state_next = READ;
            end
         end
         READ: begin
            if (rd_last) begin
               if (hop_hit) begin
                  trigger = 1'b1;
               end else begin
                  state_next = WAIT;
               end
            end else if (hop_hit) begin
               overrun_hit = 1'b1;
            end
         end
         default: begin
            state_next = FILL;
         end
      endcase
   end

   // FSM state register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= FILL;
      end else begin
         state <= state_next;
      end
   end

   // Write side runs regardless of FSM state; the buffer is twice the frame
   // length so a frame being read is never overwritten during its readout.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
      end else if (in_valid) begin
         wr_ptr <= wr_ptr + AW'(1);
      end
   end

   // Sample counters: fill_cnt primes the first frame after reset, new_cnt
   // measures the hop since the last trigger (or dropped trigger) and keeps
   // running while a frame is being read.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         fill_cnt <= '0;
         new_cnt  <= '0;
      end else begin
         if ((state == FILL) && in_valid) begin
            fill_cnt <= fill_cnt + FRAME_AW'(1);
         end
         if (trigger || overrun_hit) begin
            new_cnt <= '0;
         end else if (in_valid && (state != FILL)) begin
            new_cnt <= new_cnt + NEW_W'(1);
         end
      end
   end

   // Read address generator. On a trigger the frame base is the oldest of the
   // last FRAME_LEN samples, counting the one being written this cycle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_ptr <= '0;
         rd_cnt <= '0;
      end else if (trigger) begin
         rd_ptr <= wr_ptr - AW'(FRAME_LEN - 1);
         rd_cnt <= '0;
      end else if (rd_en) begin
         rd_ptr <= rd_ptr + AW'(1);
         rd_cnt <= rd_cnt + FRAME_AW'(1);
      end
   end

   // Frame markers travel alongside the RAM read so they line up with the
   // data coming out of the one-cycle-latency read port.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ram_vld_q <= 1'b0;
         ram_sof_q <= 1'b0;
         ram_eof_q <= 1'b0;
      end else begin
         ram_vld_q <= rd_en;
         ram_sof_q <= rd_first;
         ram_eof_q <= rd_last;
      end
   end

   // Output register stage. Data only updates with a valid sample so the bus
   // holds its last value between frames.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         out_data_F  <= '0;
         out_valid_F <= 1'b0;
         out_sof_F   <= 1'b0;
         out_eof_F   <= 1'b0;
         overrun_F   <= 1'b0;
      end else begin
         out_valid_F <= ram_vld_q;
         out_sof_F   <= ram_sof_q;
         out_eof_F   <= ram_eof_q;
         overrun_F   <= overrun_hit;
         if (ram_vld_q) begin
            out_data_F <= ram_q;
         end
      end
   end

`ifdef SEG_OVERRUN_CNT_EN
   // Dropped-frame counter, bumped together with each overrun pulse and
   // pinned at all-ones rather than wrapping.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         overrun_cnt_F <= '0;
      end else if (overrun_hit && (overrun_cnt_F != 16'hFFFF)) begin
         overrun_cnt_F <= overrun_cnt_F + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_doppler_frame_segmenter.sv
// ---------------------------------------------------------------------------
// tb_doppler_frame_segmenter
// Directed self-checking bench for doppler_frame_segmenter (FRAME_LEN=128,
// HOP=64). Input samples are ramps so every expected frame is a contiguous
// run of values whose start is worked out by hand for each scenario.
// Define SEG_OVERRUN_CNT_EN to also exercise the overrun counter.
// ---------------------------------------------------------------------------
module tb_doppler_frame_segmenter;

   localparam int DATA_W    = 32;
   localparam int FRAME_LEN = 128;
   localparam int HOP       = 64;

   logic                     clk = 1'b0;
   logic                     reset;
   logic signed [DATA_W-1:0] in_data;
   logic                     in_valid;
   logic signed [DATA_W-1:0] out_data_F;
   logic                     out_valid_F;
   logic                     out_sof_F;
   logic                     out_eof_F;
   logic                     overrun_F;
`ifdef SEG_OVERRUN_CNT_EN
   logic [15:0]              overrun_cnt_F;
`endif

   int n_cmp = 0;
   int n_err = 0;
   int ovr_cycles = 0;

   typedef struct {
      logic [DATA_W-1:0] d;
      logic              sof;
      logic              eof;
   } ent_t;

   ent_t q[$];

   doppler_frame_segmenter #(
      .DATA_W    (DATA_W),
      .FRAME_LEN (FRAME_LEN),
      .HOP       (HOP)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .in_data     (in_data),
      .in_valid    (in_valid),
      .out_data_F  (out_data_F),
      .out_valid_F (out_valid_F),
      .out_sof_F   (out_sof_F),
      .out_eof_F   (out_eof_F),
      .overrun_F   (overrun_F)
`ifdef SEG_OVERRUN_CNT_EN
      ,
      .overrun_cnt_F (overrun_cnt_F)
`endif
   );

   // Free-running 10-unit clock.
   always #5 clk = ~clk;

   // Output monitor: every valid output beat is logged on the falling edge,
   // and cycles with overrun_F high are counted.
   always @(negedge clk) begin
      ent_t e;
      if (out_valid_F === 1'b1) begin
         e.d   = out_data_F;
         e.sof = out_sof_F;
         e.eof = out_eof_F;
         q.push_back(e);
      end
      if (overrun_F === 1'b1) begin
         ovr_cycles++;
      end
   end

   // Safety net in case something stalls outside the bounded waits.
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   // Drive one sample from a falling edge, then idle for gap cycles.
   task automatic send(input int v, input int gap);
      in_data  = v;
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (gap) @(negedge clk);
   endtask

   // Reset values of every output while reset is held, and just after release.
   task automatic test_reset();
      reset    = 1'b1;
      in_valid = 1'b0;
      in_data  = '0;
      repeat (3) @(negedge clk);
      n_cmp++; if (out_data_F !== '0) begin n_err++; $display("[TB] FAIL reset_data: got %0d need 0", out_data_F); end
      n_cmp++; if (out_valid_F !== 1'b0) begin n_err++; $display("[TB] FAIL reset_valid: got %b need 0", out_valid_F); end
      n_cmp++; if (out_sof_F !== 1'b0) begin n_err++; $display("[TB] FAIL reset_sof: got %b need 0", out_sof_F); end
      n_cmp++; if (out_eof_F !== 1'b0) begin n_err++; $display("[TB] FAIL reset_eof: got %b need 0", out_eof_F); end
      n_cmp++; if (overrun_F !== 1'b0) begin n_err++; $display("[TB] FAIL reset_overrun: got %b need 0", overrun_F); end
`ifdef SEG_OVERRUN_CNT_EN
      n_cmp++; if (overrun_cnt_F !== 16'd0) begin n_err++; $display("[TB] FAIL reset_ovr_cnt: got %0d need 0", overrun_cnt_F); end
`endif
      reset = 1'b0;
      @(negedge clk);
      n_cmp++; if (out_valid_F !== 1'b0) begin n_err++; $display("[TB] FAIL post_reset_valid: got %b need 0", out_valid_F); end
   endtask

   // First frame after reset: exact two-cycle latency from the capturing edge
   // of sample 128, then 128 back-to-back beats 1..128 with sof/eof markers.
   task automatic test_initial_fill();
      for (int v = 1; v <= FRAME_LEN; v++) send(v, 0);
      n_cmp++; if (out_valid_F !== 1'b0) begin n_err++; $display("[TB] FAIL fill_lat1_valid: got %b need 0", out_valid_F); end
      @(negedge clk);
      n_cmp++; if (out_valid_F !== 1'b0) begin n_err++; $display("[TB] FAIL fill_lat2_valid: got %b need 0", out_valid_F); end
      for (int i = 1; i <= FRAME_LEN; i++) begin
         @(negedge clk);
         n_cmp++;
         if ((out_valid_F !== 1'b1) || (out_data_F !== DATA_W'(i)) ||
             (out_sof_F !== (i == 1)) || (out_eof_F !== (i == FRAME_LEN))) begin
            n_err++;
            $display("[TB] FAIL fill_beat%0d: got v=%b d=%0d sof=%b eof=%b need v=1 d=%0d sof=%b eof=%b",
                     i, out_valid_F, out_data_F, out_sof_F, out_eof_F, i, (i == 1), (i == FRAME_LEN));
         end
      end
      @(negedge clk);
      n_cmp++; if (out_valid_F !== 1'b0) begin n_err++; $display("[TB] FAIL fill_end_valid: got %b need 0", out_valid_F); end
      n_cmp++; if (out_data_F !== DATA_W'(128)) begin n_err++; $display("[TB] FAIL fill_hold_data: got %0d need 128", out_data_F); end
      n_cmp++; if (ovr_cycles !== 0) begin n_err++; $display("[TB] FAIL fill_overrun: got %0d need 0", ovr_cycles); end
   endtask

   // Sparse hop of 64 samples 129..192 (1 in 4): one overlapping frame 65..192.
   task automatic test_sparse_overlap();
      int base;
      base = q.size();
      for (int v = 129; v <= 192; v++) send(v, 3);
      for (int c = 0; (c < 400) && (q.size() < base + FRAME_LEN); c++) @(negedge clk);
      repeat (4) @(negedge clk);
      n_cmp++; if (q.size() !== base + FRAME_LEN) begin n_err++; $display("[TB] FAIL sparse_count: got %0d need %0d", q.size() - base, FRAME_LEN); end
      if (q.size() >= base + FRAME_LEN) begin
         for (int i = 0; i < FRAME_LEN; i++) begin
            n_cmp++;
            if ((q[base+i].d !== DATA_W'(65 + i)) || (q[base+i].sof !== (i == 0)) || (q[base+i].eof !== (i == FRAME_LEN-1))) begin
               n_err++;
               $display("[TB] FAIL sparse_beat%0d: got d=%0d sof=%b eof=%b need d=%0d", i, q[base+i].d, q[base+i].sof, q[base+i].eof, 65 + i);
            end
         end
      end
      n_cmp++; if (ovr_cycles !== 0) begin n_err++; $display("[TB] FAIL sparse_overrun: got %0d need 0", ovr_cycles); end
   endtask

   // Full rate 193..492: triggers at 256 and 384 are serviced (the latter on
   // the last read cycle), those at 320 and 448 land mid-frame and are dropped.
   task automatic test_overrun();
      int base;
      int start;
      base = q.size();
      for (int v = 193; v <= 492; v++) send(v, 0);
      for (int c = 0; (c < 400) && (q.size() < base + 2*FRAME_LEN); c++) @(negedge clk);
      repeat (4) @(negedge clk);
      n_cmp++; if (q.size() !== base + 2*FRAME_LEN) begin n_err++; $display("[TB] FAIL ovr_count: got %0d need %0d", q.size() - base, 2*FRAME_LEN); end
      if (q.size() >= base + 2*FRAME_LEN) begin
         for (int f = 0; f < 2; f++) begin
            start = 129 + 128*f;
            for (int i = 0; i < FRAME_LEN; i++) begin
               n_cmp++;
               if ((q[base+f*FRAME_LEN+i].d !== DATA_W'(start + i)) ||
                   (q[base+f*FRAME_LEN+i].sof !== (i == 0)) || (q[base+f*FRAME_LEN+i].eof !== (i == FRAME_LEN-1))) begin
                  n_err++;
                  $display("[TB] FAIL ovr_f%0d_beat%0d: got d=%0d need d=%0d", f, i, q[base+f*FRAME_LEN+i].d, start + i);
               end
            end
         end
      end
      n_cmp++; if (ovr_cycles !== 2) begin n_err++; $display("[TB] FAIL ovr_pulses: got %0d need 2", ovr_cycles); end
`ifdef SEG_OVERRUN_CNT_EN
      n_cmp++; if (overrun_cnt_F !== 16'd2) begin n_err++; $display("[TB] FAIL ovr_cnt: got %0d need 2", overrun_cnt_F); end
`endif
   endtask

   // 1000 sparse samples 493..1492 from a hop count of 44: frames end at
   // 512, 576, ... 1472, i.e. 16 frames starting 385 and advancing by 64.
   task automatic test_wraparound();
      int base;
      int start;
      base = q.size();
      for (int v = 493; v <= 1492; v++) send(v, 3);
      for (int c = 0; (c < 500) && (q.size() < base + 16*FRAME_LEN); c++) @(negedge clk);
      repeat (4) @(negedge clk);
      n_cmp++; if (q.size() !== base + 16*FRAME_LEN) begin n_err++; $display("[TB] FAIL wrap_count: got %0d need %0d", q.size() - base, 16*FRAME_LEN); end
      if (q.size() >= base + 16*FRAME_LEN) begin
         for (int f = 0; f < 16; f++) begin
            start = 385 + 64*f;
            for (int i = 0; i < FRAME_LEN; i++) begin
               n_cmp++;
               if ((q[base+f*FRAME_LEN+i].d !== DATA_W'(start + i)) ||
                   (q[base+f*FRAME_LEN+i].sof !== (i == 0)) || (q[base+f*FRAME_LEN+i].eof !== (i == FRAME_LEN-1))) begin
                  n_err++;
                  $display("[TB] FAIL wrap_f%0d_beat%0d: got d=%0d sof=%b eof=%b need d=%0d", f, i,
                           q[base+f*FRAME_LEN+i].d, q[base+f*FRAME_LEN+i].sof, q[base+f*FRAME_LEN+i].eof, start + i);
               end
            end
         end
      end
      n_cmp++; if (ovr_cycles !== 2) begin n_err++; $display("[TB] FAIL wrap_overrun: got %0d need 2", ovr_cycles); end
   endtask

   // Reset asserted on output beat 50 of a fresh frame: outputs clear at once,
   // then nothing comes out until 128 new samples have been accepted.
   task automatic test_reset_midframe();
      int seen;
      int base;
      reset = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      for (int v = 1; v <= FRAME_LEN; v++) send(v, 0);
      seen = 0;
      for (int c = 0; (c < 300) && (seen < 50); c++) begin
         @(negedge clk);
         if (out_valid_F === 1'b1) seen++;
      end
      n_cmp++; if (seen !== 50) begin n_err++; $display("[TB] FAIL mid_reach50: got %0d beats need 50", seen); end
      n_cmp++; if (out_data_F !== DATA_W'(50)) begin n_err++; $display("[TB] FAIL mid_beat50_data: got %0d need 50", out_data_F); end
      reset = 1'b1;
      #1;
      n_cmp++;
      if ((out_data_F !== '0) || (out_valid_F !== 1'b0) || (out_sof_F !== 1'b0) || (out_eof_F !== 1'b0) || (overrun_F !== 1'b0)) begin
         n_err++;
         $display("[TB] FAIL mid_async_clear: got d=%0d v=%b sof=%b eof=%b ovr=%b need all 0",
                  out_data_F, out_valid_F, out_sof_F, out_eof_F, overrun_F);
      end
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      base = q.size();
      for (int v = 1001; v <= 1127; v++) send(v, 0);
      repeat (200) @(negedge clk);
      n_cmp++; if (q.size() !== base) begin n_err++; $display("[TB] FAIL mid_no_early_out: got %0d beats need 0", q.size() - base); end
      send(1128, 0);
      for (int c = 0; (c < 300) && (q.size() < base + FRAME_LEN); c++) @(negedge clk);
      repeat (4) @(negedge clk);
      n_cmp++; if (q.size() !== base + FRAME_LEN) begin n_err++; $display("[TB] FAIL mid_refill_count: got %0d need %0d", q.size() - base, FRAME_LEN); end
      if (q.size() >= base + FRAME_LEN) begin
         for (int i = 0; i < FRAME_LEN; i++) begin
            n_cmp++;
            if ((q[base+i].d !== DATA_W'(1001 + i)) || (q[base+i].sof !== (i == 0)) || (q[base+i].eof !== (i == FRAME_LEN-1))) begin
               n_err++;
               $display("[TB] FAIL mid_refill_beat%0d: got d=%0d need d=%0d", i, q[base+i].d, 1001 + i);
            end
         end
      end
   endtask

`ifdef SEG_OVERRUN_CNT_EN
   // From a fresh reset, 460 full-rate samples drop the frames due at 192,
   // 320 and 448, so the counter reads 3; reset brings it back to 0.
   task automatic test_overrun_counter();
      int ovr0;
      reset = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      ovr0 = ovr_cycles;
      for (int v = 1; v <= 460; v++) send(v, 0);
      repeat (300) @(negedge clk);
      n_cmp++; if (overrun_cnt_F !== 16'd3) begin n_err++; $display("[TB] FAIL cnt_three: got %0d need 3", overrun_cnt_F); end
      n_cmp++; if ((ovr_cycles - ovr0) !== 3) begin n_err++; $display("[TB] FAIL cnt_pulses: got %0d need 3", ovr_cycles - ovr0); end
      reset = 1'b1;
      #1;
      n_cmp++; if (overrun_cnt_F !== 16'd0) begin n_err++; $display("[TB] FAIL cnt_reset: got %0d need 0", overrun_cnt_F); end
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
   endtask
`endif

   // Scenario sequence; the later scenarios continue the sample stream left
   // by the earlier ones, so the order matters.
   initial begin
      reset    = 1'b1;
      in_valid = 1'b0;
      in_data  = '0;
      $display("[TB] start");
      test_reset();
      test_initial_fill();
      test_sparse_overlap();
      test_overrun();
      test_wraparound();
      test_reset_midframe();
`ifdef SEG_OVERRUN_CNT_EN
      test_overrun_counter();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/doppler_frame_segmenter.md
Name: doppler_frame_segmenter

Overview:
- Upstream feeder for the Hamming window stage. It converts the continuous slow-time Doppler sample stream into overlapping, frame-aligned bursts.
- Each burst is exactly FRAME_LEN samples, so the window's coefficient index restarts at 0 on every frame.
- Successive frames overlap by FRAME_LEN-HOP samples (Welch-style).
- Sits between the wall filter and the windowing/FFT chain.

Parameters:
- DATA_W, 32, sample width in bits (signed two's complement).
- FRAME_LEN, 128, samples per frame; power of two; matches the window LUT depth.
- HOP, 64, new input samples between successive frame starts; power of two; 1 <= HOP <= FRAME_LEN.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_data  in  DATA_W  signed input sample.
- in_valid  in  1  qualifies in_data; at most one sample per cycle; no backpressure.
- out_data_F  out  DATA_W  signed frame sample, registered.
- out_valid_F  out  1  qualifies out_data_F.
- out_sof_F  out  1  high with the first sample of each frame.
- out_eof_F  out  1  high with the last sample of each frame.
- overrun_F  out  1  one-cycle pulse when a frame is dropped.
- overrun_cnt_F  out  16  saturating dropped-frame count; present only with SEG_OVERRUN_CNT_EN.

Behaviour:
- Storage
  - Circular buffer, depth 2*FRAME_LEN, synchronous write and synchronous read (one-cycle read latency).
  - wr_ptr has log2(2*FRAME_LEN) bits and wraps modulo depth.
- Write side: independent of state.
  - Every in_valid cycle writes in_data at wr_ptr and increments wr_ptr.
  - The write side never stalls.
- FSM states: FILL, WAIT, READ.
- FILL
  - Counts accepted samples.
  - The cycle that accepts the FRAME_LEN-th sample after reset is a trigger.
- WAIT
  - new_cnt counts samples accepted since the last trigger.
  - The cycle in which the HOP-th sample is accepted is a trigger.
- On a trigger:
  - frame_base <= wr_ptr+1-FRAME_LEN (mod depth), i.e. the oldest of the last FRAME_LEN samples including the triggering one.
  - new_cnt <= 0.
  - FSM -> READ.
- READ
  - Issues FRAME_LEN consecutive read addresses frame_base..frame_base+FRAME_LEN-1 (mod depth), one per cycle, with no gaps.
  - Returns to WAIT after the last address.
  - new_cnt keeps counting during READ.
- Latency and output timing
  - First out_valid_F is 2 cycles after the clock edge that captured the triggering sample.
  - out_valid_F is then high for exactly FRAME_LEN consecutive cycles.
  - out_sof_F is high on the first of these cycles; out_eof_F on the last.
  - Outside frames: out_valid_F, out_sof_F and out_eof_F are 0, and out_data_F holds its last value.
- Buffer safety: a frame occupies FRAME_LEN slots. At most FRAME_LEN writes can occur during its FRAME_LEN-cycle readout, so the unread portion is never overwritten.
- Overrun
  - A trigger arising while in READ is not queued.
  - That frame is dropped, overrun_F pulses for 1 cycle and new_cnt resets to 0.
  - The current frame completes unaffected.
- Simultaneous events
  - in_valid on the last READ cycle is counted normally.
  - A trigger on the cycle READ→WAIT occurs is serviced: it enters READ on the next cycle and is not an overrun.
- Reset, asserted at any time including mid-frame:
  - Immediately: out_data_F=0, out_valid_F=0, out_sof_F=0, out_eof_F=0, overrun_F=0, overrun_cnt_F=0.
  - wr_ptr=0, new_cnt=0, fill count=0, FSM=FILL.
  - A partially emitted frame is abandoned without out_eof_F.
  - Buffer contents are not cleared but are never read before a fresh fill.

Optional Feature:
- Macro: SEG_OVERRUN_CNT_EN.
- Defined:
  - overrun_cnt_F port exists.
  - Increments on each overrun_F pulse and saturates at 16'hFFFF.
  - Cleared only by reset.
- Undefined: port and counter absent; overrun_F pulse is unchanged.

Decomposition:
- Shared package sdu_pkg holds:
  - SDU_DATA_W = 32.
  - SDU_FRAME_LEN = 128.
  - SDU_FRAME_AW = 7, the frame address width shared with the window LUT.
  - The segmenter state enum typedef {FILL, WAIT, READ}.
- One sub-module: seg_frame_ram, the simple dual-port synchronous RAM (depth 2*FRAME_LEN, DATA_W wide), kept separate for block-RAM inference.

Test Plan:
- Initial fill timing
  - Stimulus: reset, then 128 samples 1..128 with continuous in_valid.
  - Response: one frame 1..128; out_sof_F with value 1, 2 cycles after sample 128 is captured; out_eof_F with value 128.
- Overlapping frames at sparse rate
  - Stimulus: continue with 64 samples 129..192, with in_valid 1 cycle in 4.
  - Response: second frame 65..192, no overrun_F.
- Overrun
  - Stimulus: after the first frame, feed full-rate input of 300 samples.
  - Response: frames dropped whenever a trigger lands in READ; overrun_F pulses counted.
  - Every emitted frame is still contiguous and correctly ordered.
- Pointer wrap-around
  - Stimulus: 1000 sparse samples (ramp).
  - Response: every frame is a strictly increasing ramp of 128 values; frame starts advance by 64; this exercises wrap of the depth-256 buffer.
- Reset mid-frame
  - Stimulus: assert reset at output sample 50 of a frame.
  - Response: all outputs 0 immediately; no further output until 128 new samples are accepted.
- Optional counter, with SEG_OVERRUN_CNT_EN defined
  - Stimulus: force 3 overruns.
  - Response: overrun_cnt_F = 3; reset returns it to 0.
